// File: rtl/controller_fsm_pkg.sv
// Shared types and encodings for the fetch/decode/execute controller.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

endpackage

// File: rtl/controller_fsm_if.sv
// Controller <-> datapath bundle: instruction in, PC/IR/RAM/RF/ALU controls out.
interface controller_fsm_if;
  logic [15:0] ir;
  logic        pc_clr;
  logic        pc_up;
  logic        ir_ld;
  logic [7:0]  d_addr;
  logic        d_wr;
  logic        rf_s;
  logic [3:0]  rf_w_addr;
  logic        rf_w_en;
  logic [3:0]  rf_ra_addr;
  logic [3:0]  rf_rb_addr;
  logic [2:0]  alu_s0;
  logic [3:0]  state_out;

  modport master (
    input  ir,
    output pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s, rf_w_addr, rf_w_en,
           rf_ra_addr, rf_rb_addr, alu_s0, state_out
  );

  modport slave (
    output ir,
    input  pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s, rf_w_addr, rf_w_en,
           rf_ra_addr, rf_rb_addr, alu_s0, state_out
  );
endinterface

// File: rtl/controller_fsm_ir_field_decode.sv
// Splits the 16-bit instruction into its opcode and operand fields.
module ir_field_decode (
  input  logic [15:0] ir,
  output logic [3:0]  op,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [3:0]  rq,
  output logic [7:0]  addr_ld,
  output logic [7:0]  addr_st
);

  // LOAD carries its address in [11:4], STORE in [7:0]
  assign op      = ir[15:12];
  assign ra      = ir[11:8];
  assign rb      = ir[7:4];
  assign rq      = ir[3:0];
  assign addr_ld = ir[11:4];
  assign addr_st = ir[7:0];

endmodule

// File: rtl/controller_fsm.sv
// Moore fetch/decode/execute sequencer driving PC, IR, data RAM, register file and ALU.
//
// state  | meaning
// INIT   | clear PC after reset
// FETCH  | load IR, advance PC
// DECODE | branch on opcode
// NOOP   | idle execute slot (also illegal opcodes)
// LOAD_A | present RAM address, wait RAM_RD_LAT cycles
// LOAD_B | write RAM data into RF[rq]
// STORE  | write RF[ra] into RAM
// ADD    | RF[rq] <= RF[ra] + RF[rb]
// SUB    | RF[rq] <= RF[ra] - RF[rb]
// HALT   | terminal, left only by reset
module controller_fsm
  import ctrl_pkg::*;
#(
  parameter int RAM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  controller_fsm_if.master  bus
);

  localparam logic [2:0] WAIT_TC = 3'(RAM_RD_LAT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] wait_cnt;

  logic [3:0] op;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rq;
  logic [7:0] addr_ld;
  logic [7:0] addr_st;

  ir_field_decode u_dec (
    .ir      (bus.ir),
    .op      (op),
    .ra      (ra),
    .rb      (rb),
    .rq      (rq),
    .addr_ld (addr_ld),
    .addr_st (addr_st)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INIT;
      wait_cnt <= 3'd0;
    end else begin
      state <= state_nxt;
      // counts only while LOAD_A persists, so it restarts at 0 on every entry
      if (state == S_LOAD_A && state_nxt == S_LOAD_A) begin
        wait_cnt <= wait_cnt + 3'd1;
      end else begin
        wait_cnt <= 3'd0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:   state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_STORE: state_nxt = S_STORE;
          OP_LOAD:  state_nxt = S_LOAD_A;
          OP_ADD:   state_nxt = S_ADD;
          OP_SUB:   state_nxt = S_SUB;
          OP_HALT:  state_nxt = S_HALT;
          default:  state_nxt = S_NOOP;
        endcase
      end
      S_LOAD_A: begin
        if (wait_cnt == WAIT_TC) begin
          state_nxt = S_LOAD_B;
        end
      end
      S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    bus.pc_clr     = 1'b0;
    bus.pc_up      = 1'b0;
    bus.ir_ld      = 1'b0;
    bus.d_addr     = 8'd0;
    bus.d_wr       = 1'b0;
    bus.rf_s       = 1'b0;
    bus.rf_w_addr  = 4'd0;
    bus.rf_w_en    = 1'b0;
    bus.rf_ra_addr = 4'd0;
    bus.rf_rb_addr = 4'd0;
    bus.alu_s0     = ALU_PASS;
    bus.state_out  = state;
    case (state)
      S_INIT:  bus.pc_clr = 1'b1;
      S_FETCH: begin
        bus.ir_ld = 1'b1;
        bus.pc_up = 1'b1;
      end
      S_LOAD_A: begin
        bus.d_addr = addr_ld;
        bus.rf_s   = 1'b1;
      end
      S_LOAD_B: begin
        bus.d_addr    = addr_ld;
        bus.rf_s      = 1'b1;
        bus.rf_w_addr = rq;
        bus.rf_w_en   = 1'b1;
      end
      S_STORE: begin
        bus.d_addr     = addr_st;
        bus.rf_ra_addr = ra;
        bus.d_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        bus.rf_ra_addr = ra;
        bus.rf_rb_addr = rb;
        bus.alu_s0     = (state == S_ADD) ? ALU_ADD : ALU_SUB;
        bus.rf_w_addr  = rq;
        bus.rf_w_en    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controller_fsm.sv
// Self-checking bench: two controllers (RAM latency 1 and 3) fed by an IR register model.
module tb_controller_fsm;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_clr;
    logic       pc_up;
    logic       ir_ld;
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic [3:0] w_addr;
    logic       w_en;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] alu;
  } obs_t;

  typedef struct {
    int          k;
    logic [15:0] ir;
    obs_t        exec;
    int          len;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  controller_fsm_if bus_a ();
  controller_fsm_if bus_b ();

  controller_fsm #(.RAM_RD_LAT(1)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  controller_fsm #(.RAM_RD_LAT(3)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  logic [15:0] pend [2] = '{16'h0000, 16'h0000};
  logic        ovr_en [2] = '{1'b0, 1'b0};
  logic [15:0] ovr_val [2] = '{16'h0000, 16'h0000};
  logic [15:0] ir_reg_a;
  logic [15:0] ir_reg_b;
  int          pc_a;
  int          pc_b;
  obs_t        obs_a;
  obs_t        obs_b;
  obs_t        trace [16];
  int          trace_n;
  int          n_cmp = 0;
  int          n_bad = 0;

  // IR register and PC register of the surrounding datapath
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ir_reg_a <= 16'h0000;
    else if (bus_a.ir_ld) ir_reg_a <= pend[0];
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ir_reg_b <= 16'h0000;
    else if (bus_b.ir_ld) ir_reg_b <= pend[1];
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_a <= 0;
    else if (bus_a.pc_clr) pc_a <= 0;
    else if (bus_a.pc_up) pc_a <= pc_a + 1;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_b <= 0;
    else if (bus_b.pc_clr) pc_b <= 0;
    else if (bus_b.pc_up) pc_b <= pc_b + 1;
  end

  assign bus_a.ir = ovr_en[0] ? ovr_val[0] : ir_reg_a;
  assign bus_b.ir = ovr_en[1] ? ovr_val[1] : ir_reg_b;

  always_comb obs_a = '{state: bus_a.state_out, pc_clr: bus_a.pc_clr, pc_up: bus_a.pc_up,
                        ir_ld: bus_a.ir_ld, d_addr: bus_a.d_addr, d_wr: bus_a.d_wr,
                        rf_s: bus_a.rf_s, w_addr: bus_a.rf_w_addr, w_en: bus_a.rf_w_en,
                        ra: bus_a.rf_ra_addr, rb: bus_a.rf_rb_addr, alu: bus_a.alu_s0};
  always_comb obs_b = '{state: bus_b.state_out, pc_clr: bus_b.pc_clr, pc_up: bus_b.pc_up,
                        ir_ld: bus_b.ir_ld, d_addr: bus_b.d_addr, d_wr: bus_b.d_wr,
                        rf_s: bus_b.rf_s, w_addr: bus_b.rf_w_addr, w_en: bus_b.rf_w_en,
                        ra: bus_b.rf_ra_addr, rb: bus_b.rf_rb_addr, alu: bus_b.alu_s0};

  function automatic obs_t get_obs(int k);
    return (k == 0) ? obs_a : obs_b;
  endfunction

  function automatic int get_pc(int k);
    return (k == 0) ? pc_a : pc_b;
  endfunction

  function automatic obs_t mk(logic [3:0] st, logic [7:0] da, logic dw, logic rs,
                              logic [3:0] wa, logic we, logic [3:0] ra, logic [3:0] rb,
                              logic [2:0] alu);
    obs_t o;
    o = '0;
    o.state = st; o.d_addr = da; o.d_wr = dw; o.rf_s = rs;
    o.w_addr = wa; o.w_en = we; o.ra = ra; o.rb = rb; o.alu = alu;
    return o;
  endfunction

  function automatic obs_t mk_init();
    obs_t o;
    o = '0;
    o.pc_clr = 1'b1;
    return o;
  endfunction

  function automatic void push(obs_t o);
    trace[trace_n] = o;
    trace_n = trace_n + 1;
  endfunction

  // Expected per-cycle outputs of one instruction from FETCH up to the next FETCH
  function automatic void build_trace(logic [15:0] ir, int lat);
    obs_t       o;
    logic [3:0] op;
    op = ir[15:12];
    trace_n = 0;
    o = '0; o.state = 4'd1; o.ir_ld = 1'b1; o.pc_up = 1'b1;
    push(o);
    push(mk(4'd2, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0));
    case (op)
      4'd1: push(mk(4'd6, ir[7:0], 1, 0, 4'h0, 0, ir[11:8], 4'h0, 3'd0));
      4'd2: begin
        for (int i = 0; i < lat; i++) push(mk(4'd4, ir[11:4], 0, 1, 4'h0, 0, 4'h0, 4'h0, 3'd0));
        push(mk(4'd5, ir[11:4], 0, 1, ir[3:0], 1, 4'h0, 4'h0, 3'd0));
      end
      4'd3: push(mk(4'd7, 8'h00, 0, 0, ir[3:0], 1, ir[11:8], ir[7:4], 3'd1));
      4'd4: push(mk(4'd8, 8'h00, 0, 0, ir[3:0], 1, ir[11:8], ir[7:4], 3'd2));
      4'd5: push(mk(4'd9, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0));
      default: push(mk(4'd3, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0));
    endcase
  endfunction

  task automatic check(string name, obs_t act, obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_fetch(int k);
    obs_t o;
    int   n;
    n = 0;
    o = get_obs(k);
    while (o.state != 4'd1 && n < 20) begin
      @(negedge clk);
      n++;
      o = get_obs(k);
    end
    check_int($sformatf("sync k%0d to fetch", k), int'(o.state), 1);
  endtask

  task automatic run_instr(int k, logic [15:0] ir_v);
    int p0;
    build_trace(ir_v, (k == 0) ? 1 : 3);
    p0 = get_pc(k);
    pend[k] = ir_v;
    for (int i = 0; i < trace_n; i++) begin
      check($sformatf("trace k%0d ir %h step %0d", k, ir_v, i), get_obs(k), trace[i]);
      @(negedge clk);
    end
    check_int($sformatf("pc step k%0d ir %h", k, ir_v), get_pc(k), p0 + 1);
  endtask

  task automatic run_vec(vec_t v);
    obs_t o;
    int   cyc;
    int   p0;
    p0 = get_pc(v.k);
    pend[v.k] = v.ir;
    @(negedge clk);
    @(negedge clk);
    check($sformatf("exec k%0d ir %h", v.k, v.ir), get_obs(v.k), v.exec);
    cyc = 2;
    o = get_obs(v.k);
    while (o.state != 4'd1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      o = get_obs(v.k);
    end
    check_int($sformatf("len k%0d ir %h", v.k, v.ir), cyc, v.len);
    check_int($sformatf("pc once k%0d ir %h", v.k, v.ir), get_pc(v.k), p0 + 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vecs [9];
    logic [15:0] rir;
    int          rk;
    obs_t        o;

    vecs[0] = '{0, 16'h0000, mk(4'd3, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0), 3};
    vecs[1] = '{0, 16'h2A53, mk(4'd4, 8'hA5, 0, 1, 4'h0, 0, 4'h0, 4'h0, 3'd0), 4};
    vecs[2] = '{1, 16'h2A53, mk(4'd4, 8'hA5, 0, 1, 4'h0, 0, 4'h0, 4'h0, 3'd0), 6};
    vecs[3] = '{0, 16'h1742, mk(4'd6, 8'h42, 1, 0, 4'h0, 0, 4'h7, 4'h0, 3'd0), 3};
    vecs[4] = '{0, 16'h3129, mk(4'd7, 8'h00, 0, 0, 4'h9, 1, 4'h1, 4'h2, 3'd1), 3};
    vecs[5] = '{0, 16'h4129, mk(4'd8, 8'h00, 0, 0, 4'h9, 1, 4'h1, 4'h2, 3'd2), 3};
    vecs[6] = '{0, 16'hF123, mk(4'd3, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0), 3};
    vecs[7] = '{1, 16'h3129, mk(4'd7, 8'h00, 0, 0, 4'h9, 1, 4'h1, 4'h2, 3'd1), 3};
    vecs[8] = '{1, 16'h6ABC, mk(4'd3, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0), 3};

    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset k0", obs_a, mk_init());
    check("reset k1", obs_b, mk_init());
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      wait_fetch(vecs[i].k);
      run_vec(vecs[i]);
    end

    wait_fetch(0);
    run_instr(0, 16'h2A53);
    wait_fetch(1);
    run_instr(1, 16'h2A53);

    for (int i = 0; i < 40; i++) begin
      rk  = int'($urandom_range(0, 1));
      rir = 16'($urandom);
      if (rir[15:12] == 4'd5) rir[15:12] = 4'd0;
      wait_fetch(rk);
      run_instr(rk, rir);
    end

    // HALT holds with all outputs low while ir wanders
    wait_fetch(0);
    run_instr(0, 16'h5000);
    ovr_en[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ovr_val[0] = 16'($urandom);
      #1;
      check($sformatf("halt hold %0d", i), obs_a, mk(4'd9, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0));
      @(negedge clk);
    end
    ovr_en[0] = 1'b0;
    pend[0] = 16'h0000;
    #2 rst_n = 1'b0;
    #1 check("halt async reset", obs_a, mk_init());
    @(negedge clk);
    rst_n = 1'b1;
    wait_fetch(0);
    run_instr(0, 16'hF123);

    // reset landing in the middle of LOAD_A must abandon the write-back
    wait_fetch(1);
    pend[1] = 16'h2A53;
    @(negedge clk);
    @(negedge clk);
    check("mid load in LOAD_A", obs_b, mk(4'd4, 8'hA5, 0, 1, 4'h0, 0, 4'h0, 4'h0, 3'd0));
    pend[1] = 16'h0000;
    #2 rst_n = 1'b0;
    #1 check("mid load async reset", obs_b, mk_init());
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      o = obs_b;
      check_int($sformatf("no write after reset %0d", i), int'(o.w_en), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
